// File: rtl/dmem_load_ext.sv
// Load-side extract/extend unit: waits for the data-memory response, returns a sign/zero-extended result.
// Define DMEM_LOAD_MISALIGN_EXC_EN to reject misaligned lw/lh/lhu with ld_err instead of accessing memory.
module dmem_load_ext #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        lw,
   input  logic        lh,
   input  logic        lhu,
   input  logic        lb,
   input  logic        lbu,
   input  logic [1:0]  byteaddr,
   output logic        req_ready,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic [31:0] ld_data,
   output logic        ld_valid,
   input  logic        ld_ready,
   output logic        ld_err,
   output logic        stall
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   typedef enum logic [2:0] {LT_W, LT_H, LT_HU, LT_B, LT_BU} ltype_t;

   state_t             state, state_nxt;
   ltype_t             ltype, ltype_nxt, req_type;
   logic [1:0]         ba_q, ba_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [31:0]        data_nxt, ext, shifted;
   logic               valid_nxt, err_nxt, any_type, misalign;
   logic [15:0]        half;
   logic [7:0]         byte_sel;

   always_comb begin
      any_type = lw | lh | lhu | lb | lbu;
      if (lw)       req_type = LT_W;
      else if (lh)  req_type = LT_H;
      else if (lhu) req_type = LT_HU;
      else if (lb)  req_type = LT_B;
      else          req_type = LT_BU;
`ifdef DMEM_LOAD_MISALIGN_EXC_EN
      misalign = ((req_type == LT_W) && (byteaddr != 2'b00)) ||
                 (((req_type == LT_H) || (req_type == LT_HU)) && byteaddr[0]);
`else
      misalign = 1'b0;
`endif
   end

   // Extraction always works from the captured type/address, never the live request inputs.
   always_comb begin
      shifted  = rdata >> {ba_q, 3'b000};
      byte_sel = shifted[7:0];
      half     = ba_q[1] ? rdata[31:16] : rdata[15:0];
      unique case (ltype)
         LT_W:    ext = rdata;
         LT_H:    ext = {{16{half[15]}}, half};
         LT_HU:   ext = {16'h0000, half};
         LT_B:    ext = {{24{byte_sel[7]}}, byte_sel};
         LT_BU:   ext = {24'h00_0000, byte_sel};
         default: ext = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      ltype_nxt = ltype;
      ba_nxt    = ba_q;
      cnt_nxt   = cnt;
      data_nxt  = ld_data;
      valid_nxt = ld_valid;
      err_nxt   = ld_err;
      stall     = 1'b1;
      req_ready = 1'b0;
      unique case (state)
         S_IDLE: begin
            stall     = 1'b0;
            req_ready = 1'b1;
            if (req_valid && any_type) begin
               ltype_nxt = req_type;
               ba_nxt    = byteaddr;
               cnt_nxt   = '0;
               if (misalign) begin
                  data_nxt  = '0;
                  err_nxt   = 1'b1;
                  valid_nxt = 1'b1;
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (rvalid) begin
               data_nxt  = ext;
               err_nxt   = 1'b0;
               valid_nxt = 1'b1;
               state_nxt = S_DONE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               data_nxt  = '0;
               err_nxt   = 1'b1;
               valid_nxt = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (ld_ready) begin
               valid_nxt = 1'b0;
               err_nxt   = 1'b0;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         ltype    <= LT_W;
         ba_q     <= '0;
         cnt      <= '0;
         ld_data  <= '0;
         ld_valid <= 1'b0;
         ld_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         ltype    <= ltype_nxt;
         ba_q     <= ba_nxt;
         cnt      <= cnt_nxt;
         ld_data  <= data_nxt;
         ld_valid <= valid_nxt;
         ld_err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_dmem_load_ext.sv
// Scoreboard bench for dmem_load_ext: expected results queued at request time, compared when ld_valid appears.
module tb_dmem_load_ext;

   localparam int unsigned TO = 16;

   localparam logic [4:0] T_LW  = 5'b10000;
   localparam logic [4:0] T_LH  = 5'b01000;
   localparam logic [4:0] T_LHU = 5'b00100;
   localparam logic [4:0] T_LB  = 5'b00010;
   localparam logic [4:0] T_LBU = 5'b00001;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        lw = 1'b0, lh = 1'b0, lhu = 1'b0, lb = 1'b0, lbu = 1'b0;
   logic [1:0]  byteaddr = '0;
   logic        req_ready;
   logic [31:0] rdata = '0;
   logic        rvalid = 1'b0;
   logic [31:0] ld_data;
   logic        ld_valid;
   logic        ld_ready = 1'b0;
   logic        ld_err;
   logic        stall;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t sb[$];

   dmem_load_ext #(.TIMEOUT(TO), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid),
      .lw(lw), .lh(lh), .lhu(lhu), .lb(lb), .lbu(lbu),
      .byteaddr(byteaddr), .req_ready(req_ready),
      .rdata(rdata), .rvalid(rvalid),
      .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_err(ld_err), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic set_type(input logic [4:0] t);
      {lw, lh, lhu, lb, lbu} = t;
   endtask

   // Request driven in cycle 0 (with a decoy rvalid that must be ignored), rvalid pulsed in cycle n_rv (0 = never).
   task automatic run_load(input string tag, input logic [4:0] t, input logic [1:0] ba,
                           input logic [31:0] rd, input int n_rv, input int hold,
                           input logic [31:0] ed, input logic ee, input int lat);
      exp_t e;
      int   cyc;
      bit   seen;
      sb.push_back('{data: ed, err: ee});
      set_type(t);
      byteaddr  = ba;
      rdata     = rd;
      req_valid = 1'b1;
      rvalid    = 1'b1;
      #1 check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 40) begin
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         set_type(5'b00000);
         cyc++;
         rvalid = (cyc == n_rv);
         @(negedge clk);
         if (cyc == 1) check({tag, "_stall"}, 32'(stall), 32'd1);
         seen = ld_valid;
      end
      if (!seen) begin
         check({tag, "_no_ld_valid"}, 32'd0, 32'd1);
      end else begin
         check({tag, "_latency"}, 32'(cyc), 32'(lat));
         e = sb.pop_front();
         check({tag, "_data"}, ld_data, e.data);
         check({tag, "_err"}, 32'(ld_err), 32'(e.err));
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1 rvalid = (h == 0);
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(ld_valid), 32'd1);
         check({tag, "_hold_data"}, ld_data, ed);
         check({tag, "_hold_stall"}, 32'(stall), 32'd1);
      end
      @(posedge clk);
      #1;
      rvalid   = 1'b0;
      ld_ready = 1'b1;
      @(posedge clk);
      #1 ld_ready = 1'b0;
      @(negedge clk);
      check({tag, "_released_valid"}, 32'(ld_valid), 32'd0);
      check({tag, "_released_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_released_stall"}, 32'(stall), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_data", ld_data, 32'h0);
      check("rst_valid", 32'(ld_valid), 32'd0);
      check("rst_err", 32'(ld_err), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);
      reset = 1'b0;

      run_load("lb_b3",   T_LB,  2'd3, 32'h80FF_1234, 2, 0, 32'hFFFF_FF80, 1'b0, 3);
      run_load("lbu_b3",  T_LBU, 2'd3, 32'h80FF_1234, 2, 0, 32'h0000_0080, 1'b0, 3);
      run_load("lhu_b2",  T_LHU, 2'd2, 32'h80FF_1234, 2, 0, 32'h0000_80FF, 1'b0, 3);
      run_load("lh_b0",   T_LH,  2'd0, 32'h80FF_1234, 2, 0, 32'h0000_1234, 1'b0, 3);
      run_load("lh_b2",   T_LH,  2'd2, 32'h80FF_1234, 1, 0, 32'hFFFF_80FF, 1'b0, 2);
      run_load("lb_b1",   T_LB,  2'd1, 32'h80FF_1234, 1, 0, 32'h0000_0012, 1'b0, 2);
      run_load("lbu_b2",  T_LBU, 2'd2, 32'h80FF_1234, 3, 0, 32'h0000_00FF, 1'b0, 4);
      run_load("lw_hold", T_LW,  2'd0, 32'hDEAD_BEEF, 3, 4, 32'hDEAD_BEEF, 1'b0, 4);
      run_load("prio_lw", T_LW | T_LB,   2'd0, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 1'b0, 2);
      run_load("prio_lhu", T_LHU | T_LBU, 2'd2, 32'h80FF_1234, 1, 0, 32'h0000_80FF, 1'b0, 2);
      run_load("timeout", T_LW,  2'd0, 32'h1234_5678, 0, 1, 32'h0000_0000, 1'b1, TO + 1);
      run_load("rv_at_to", T_LW, 2'd0, 32'h1234_5678, TO, 0, 32'h1234_5678, 1'b0, TO + 1);
`ifdef DMEM_LOAD_MISALIGN_EXC_EN
      run_load("mis_lw",  T_LW,  2'd2, 32'hDEAD_BEEF, 2, 2, 32'h0000_0000, 1'b1, 1);
      run_load("mis_lh",  T_LH,  2'd1, 32'h0000_8001, 2, 1, 32'h0000_0000, 1'b1, 1);
`else
      run_load("mis_lw",  T_LW,  2'd2, 32'hDEAD_BEEF, 2, 2, 32'hDEAD_BEEF, 1'b0, 3);
      run_load("mis_lh",  T_LH,  2'd1, 32'h0000_8001, 2, 1, 32'hFFFF_8001, 1'b0, 3);
`endif

      // Request with no type bit must be dropped.
      req_valid = 1'b1;
      set_type(5'b00000);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("notype_ready", 32'(req_ready), 32'd1);
      check("notype_stall", 32'(stall), 32'd0);

      // Reset while in WAIT, then a stale rvalid.
      set_type(T_LW);
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      set_type(5'b00000);
      @(posedge clk);
      #1 check("rw_stall_pre", 32'(stall), 32'd1);
      reset = 1'b1;
      #1;
      check("rw_stall", 32'(stall), 32'd0);
      check("rw_ready", 32'(req_ready), 32'd1);
      check("rw_valid", 32'(ld_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 rvalid = 1'b1;
      @(posedge clk);
      #1 rvalid = 1'b0;
      @(negedge clk);
      check("rw_stale_valid", 32'(ld_valid), 32'd0);
      check("rw_stale_stall", 32'(stall), 32'd0);

      // Reset while in DONE.
      set_type(T_LW);
      rdata     = 32'hCAFE_F00D;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      set_type(5'b00000);
      rvalid    = 1'b1;
      @(posedge clk);
      #1 rvalid = 1'b0;
      @(negedge clk);
      check("rd_valid_pre", 32'(ld_valid), 32'd1);
      check("rd_data_pre", ld_data, 32'hCAFE_F00D);
      #1 reset = 1'b1;
      #1;
      check("rd_data", ld_data, 32'h0);
      check("rd_valid", 32'(ld_valid), 32'd0);
      check("rd_err", 32'(ld_err), 32'd0);
      check("rd_ready", 32'(req_ready), 32'd1);
      check("rd_stall", 32'(stall), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
